// File: rtl/glb_pe_mcast.sv
// Global PE: tag-filtered X-bus multicast receiver, weight/ifmap FIFOs and a weight-stationary MAC
// engine with vertical psum chaining. Optional build macro GLB_PE_SAT_EN enables saturating accumulation.

module glb_pe_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

module glb_pe_mcast #(
    parameter  int DATA_WIDTH = 16,
    parameter  int PSUM_WIDTH = 32,
    parameter  int NUM_COL    = 4,
    parameter  int FIFO_DEPTH = 8,
    parameter  int KMAX       = 8,
    localparam int TAG_W      = $clog2(NUM_COL) + 1,
    localparam int KW         = $clog2(KMAX) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_tag_vld,
    input  logic [TAG_W-1:0]      cfg_tag,
    input  logic                  cfg_tag_clr,
    output logic                  tag_lock,
    input  logic                  cfg_start,
    input  logic [KW-1:0]         cfg_klen,
    input  logic [15:0]           cfg_nout,
    input  logic                  cfg_external,
    output logic                  busy,
`ifdef GLB_PE_SAT_EN
    output logic                  sat_flag,
`endif
    input  logic                  bus_vld,
    input  logic [TAG_W-1:0]      bus_tag,
    input  logic                  bus_kind,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_rdy,
    input  logic                  psum_in_vld,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    output logic                  psum_in_rdy,
    output logic                  psum_out_vld,
    output logic [PSUM_WIDTH-1:0] psum_out,
    input  logic                  psum_out_rdy
);
    localparam int KIW = $clog2(KMAX);
`ifdef GLB_PE_SAT_EN
    // One guard bit above the widest operand so the true sum is always representable before clamping.
    localparam int SW = ((PSUM_WIDTH > 2*DATA_WIDTH) ? PSUM_WIDTH : 2*DATA_WIDTH) + 1;
`else
    localparam int SW = PSUM_WIDTH;
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD_W, ST_MAC, ST_PSUM, ST_OUT} state_e;

    state_e                  state_q, state_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic                    tag_lock_q, tag_lock_d;
    logic                    live_q, live_d;
    logic [KW-1:0]           k_q, k_d;
    logic [KW-1:0]           klen_q, klen_d;
    logic [15:0]             n_q, n_d;
    logic [15:0]             nout_q, nout_d;
    logic                    ext_q, ext_d;
    logic signed [PSUM_WIDTH-1:0] acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] w_q [KMAX];

    logic [DATA_WIDTH-1:0]   w_dout, x_dout;
    logic                    w_full, w_empty, x_full, x_empty;
    logic                    w_push, x_push, w_pop, x_pop, w_we;
    logic                    match, acc_en, ovf;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [SW-1:0]    addend, sum_w;
    logic signed [PSUM_WIDTH-1:0] acc_sum;

    assign match = tag_lock_q && ((bus_tag == tag_q) || (bus_tag == {TAG_W{1'b1}}));
    // live_q keeps bus_rdy low while reset is asserted, without a combinational path from rst.
    assign bus_rdy = live_q && (!match || !(bus_kind ? x_full : w_full));
    assign w_push  = bus_vld && bus_rdy && match && !bus_kind;
    assign x_push  = bus_vld && bus_rdy && match && bus_kind;

    glb_pe_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_w_fifo (
        .clk(clk), .rst(rst), .push(w_push), .din(bus_data), .pop(w_pop),
        .dout(w_dout), .full(w_full), .empty(w_empty)
    );
    glb_pe_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_x_fifo (
        .clk(clk), .rst(rst), .push(x_push), .din(bus_data), .pop(x_pop),
        .dout(x_dout), .full(x_full), .empty(x_empty)
    );

    assign prod = w_q[k_q[KIW-1:0]] * $signed(x_dout);
    assign addend = (state_q == ST_MAC) ? SW'(prod) : SW'($signed(psum_in));
    assign sum_w  = SW'(acc_q) + addend;

`ifdef GLB_PE_SAT_EN
    logic [SW-PSUM_WIDTH:0] sum_hi;
    logic                   sat_flag_q, sat_flag_d;
    assign sum_hi   = sum_w[SW-1:PSUM_WIDTH-1];
    assign ovf      = !((&sum_hi) || !(|sum_hi));
    assign acc_sum  = !ovf ? sum_w[PSUM_WIDTH-1:0]
                    : (sum_w[SW-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}});
    assign sat_flag = sat_flag_q;
`else
    assign ovf     = 1'b0;
    assign acc_sum = sum_w;
`endif

    // Tag register: clear has priority and a locked tag is never overwritten.
    always_comb begin
        tag_d      = tag_q;
        tag_lock_d = tag_lock_q;
        live_d     = 1'b1;
        if (cfg_tag_clr) begin
            tag_lock_d = 1'b0;
        end else if (cfg_tag_vld && !tag_lock_q) begin
            tag_d      = cfg_tag;
            tag_lock_d = 1'b1;
        end
    end

    // NOTE: every signal driven here gets its default first, so no branch can infer a latch.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        klen_d       = klen_q;
        n_d          = n_q;
        nout_d       = nout_q;
        ext_d        = ext_q;
        acc_d        = acc_q;
        w_pop        = 1'b0;
        x_pop        = 1'b0;
        w_we         = 1'b0;
        acc_en       = 1'b0;
        psum_in_rdy  = 1'b0;
        psum_out_vld = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD_W;
                    k_d     = '0;
                    n_d     = '0;
                    ext_d   = cfg_external;
                    nout_d  = (cfg_nout == 16'd0) ? 16'd1 : cfg_nout;
                    if (cfg_klen == '0)                klen_d = KW'(1);
                    else if (cfg_klen > KW'(KMAX))     klen_d = KW'(KMAX);
                    else                               klen_d = cfg_klen;
                end
            end
            ST_LOAD_W: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    w_we  = 1'b1;
                    if (k_q == klen_q - KW'(1)) begin
                        state_d = ST_MAC;
                        k_d     = '0;
                        acc_d   = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_MAC: begin
                if (!x_empty) begin
                    x_pop  = 1'b1;
                    acc_en = 1'b1;
                    if (k_q == klen_q - KW'(1)) begin
                        state_d = ST_PSUM;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_PSUM: begin
                if (ext_q) begin
                    state_d = ST_OUT;
                end else begin
                    psum_in_rdy = 1'b1;
                    if (psum_in_vld) begin
                        acc_en  = 1'b1;
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                psum_out_vld = 1'b1;
                if (psum_out_rdy) begin
                    if (n_q + 16'd1 == nout_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_MAC;
                        n_d     = n_q + 16'd1;
                        acc_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (acc_en) acc_d = acc_sum;
    end

`ifdef GLB_PE_SAT_EN
    always_comb begin
        sat_flag_d = sat_flag_q;
        if (state_q == ST_IDLE && cfg_start) sat_flag_d = 1'b0;
        else if (acc_en && ovf)              sat_flag_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_flag_q <= 1'b0;
        else     sat_flag_q <= sat_flag_d;
    end
`endif

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            tag_lock_q <= 1'b0;
            live_q     <= 1'b0;
            k_q        <= '0;
            klen_q     <= KW'(1);
            n_q        <= '0;
            nout_q     <= 16'd1;
            ext_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            tag_lock_q <= tag_lock_d;
            live_q     <= live_d;
            k_q        <= k_d;
            klen_q     <= klen_d;
            n_q        <= n_d;
            nout_q     <= nout_d;
            ext_q      <= ext_d;
            acc_q      <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) w_q[k_q[KIW-1:0]] <= $signed(w_dout);
    end

    assign tag_lock = tag_lock_q;
    assign busy     = (state_q != ST_IDLE);
    assign psum_out = acc_q;
endmodule

// File: tb/tb_glb_pe_mcast.sv
// Directed bench for glb_pe_mcast: two instances (32-bit and 16-bit psum) share all inputs.
// Expected values are hand-computed; GLB_PE_SAT_EN selects saturated vs wrapped expectations.

module tb_glb_pe_mcast;
    logic        clk, rst;
    logic        cfg_tag_vld, cfg_tag_clr, cfg_start, cfg_external;
    logic [2:0]  cfg_tag;
    logic [3:0]  cfg_klen;
    logic [15:0] cfg_nout;
    logic        bus_vld, bus_kind;
    logic [2:0]  bus_tag;
    logic [15:0] bus_data;
    logic        psum_in_vld, psum_out_rdy;
    logic [31:0] psum_in;

    logic        a_tag_lock, a_busy, a_bus_rdy, a_psum_in_rdy, a_psum_out_vld;
    logic [31:0] a_psum_out;
    logic        b_tag_lock, b_busy, b_bus_rdy, b_psum_in_rdy, b_psum_out_vld;
    logic [15:0] b_psum_out;
`ifdef GLB_PE_SAT_EN
    logic        a_sat, b_sat;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    glb_pe_mcast #(.PSUM_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst), .cfg_tag_vld(cfg_tag_vld), .cfg_tag(cfg_tag), .cfg_tag_clr(cfg_tag_clr),
        .tag_lock(a_tag_lock), .cfg_start(cfg_start), .cfg_klen(cfg_klen), .cfg_nout(cfg_nout),
        .cfg_external(cfg_external), .busy(a_busy),
`ifdef GLB_PE_SAT_EN
        .sat_flag(a_sat),
`endif
        .bus_vld(bus_vld), .bus_tag(bus_tag), .bus_kind(bus_kind), .bus_data(bus_data), .bus_rdy(a_bus_rdy),
        .psum_in_vld(psum_in_vld), .psum_in(psum_in), .psum_in_rdy(a_psum_in_rdy),
        .psum_out_vld(a_psum_out_vld), .psum_out(a_psum_out), .psum_out_rdy(psum_out_rdy)
    );

    glb_pe_mcast #(.PSUM_WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_tag_vld(cfg_tag_vld), .cfg_tag(cfg_tag), .cfg_tag_clr(cfg_tag_clr),
        .tag_lock(b_tag_lock), .cfg_start(cfg_start), .cfg_klen(cfg_klen), .cfg_nout(cfg_nout),
        .cfg_external(cfg_external), .busy(b_busy),
`ifdef GLB_PE_SAT_EN
        .sat_flag(b_sat),
`endif
        .bus_vld(bus_vld), .bus_tag(bus_tag), .bus_kind(bus_kind), .bus_data(bus_data), .bus_rdy(b_bus_rdy),
        .psum_in_vld(psum_in_vld), .psum_in(psum_in[15:0]), .psum_in_rdy(b_psum_in_rdy),
        .psum_out_vld(b_psum_out_vld), .psum_out(b_psum_out), .psum_out_rdy(psum_out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic kind, input logic [2:0] tg, input logic [15:0] d);
        int cnt = 0;
        bus_vld = 1'b1; bus_kind = kind; bus_tag = tg; bus_data = d;
        #1;
        while (!a_bus_rdy && cnt < 20) begin
            cyc();
            cnt++;
        end
        check("send_rdy", a_bus_rdy, 1);
        cyc();
        bus_vld = 1'b0;
    endtask

    task automatic set_tag(input logic [2:0] t);
        cfg_tag_vld = 1'b1; cfg_tag = t;
        cyc();
        cfg_tag_vld = 1'b0;
    endtask

    task automatic start_job(input logic [3:0] k, input logic [15:0] n, input logic ext);
        cfg_klen = k; cfg_nout = n; cfg_external = ext; cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp_a, input logic [15:0] exp_b,
                            output int lat);
        int cnt = 0;
        while (!a_psum_out_vld && cnt < 100) begin
            cyc();
            cnt++;
        end
        lat = cnt;
        check({tag, "_vld_a"}, a_psum_out_vld, 1);
        check({tag, "_vld_b"}, b_psum_out_vld, 1);
        check({tag, "_a"}, a_psum_out, exp_a);
        check({tag, "_b"}, b_psum_out, exp_b);
        psum_out_rdy = 1'b1;
        cyc();
        psum_out_rdy = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        cfg_tag_vld = 0; cfg_tag_clr = 0; cfg_start = 0; cfg_external = 0; cfg_tag = '0;
        cfg_klen = '0; cfg_nout = '0; bus_vld = 0; bus_kind = 0; bus_tag = '0; bus_data = '0;
        psum_in_vld = 0; psum_in = '0; psum_out_rdy = 0;
        #3;
        check("rst_tag_lock", {a_tag_lock, b_tag_lock}, 2'b00);
        check("rst_busy", {a_busy, b_busy}, 2'b00);
        check("rst_bus_rdy", {a_bus_rdy, b_bus_rdy}, 2'b00);
        check("rst_psum_in_rdy", {a_psum_in_rdy, b_psum_in_rdy}, 2'b00);
        check("rst_psum_out_vld", {a_psum_out_vld, b_psum_out_vld}, 2'b00);
        check("rst_psum_out", {a_psum_out, b_psum_out}, 48'd0);
        @(negedge clk) rst = 1'b0;
        cyc();

        // Broadcast while unlocked is ignored but still acknowledged.
        bus_vld = 1'b1; bus_kind = 1'b1; bus_tag = 3'b111; bus_data = 16'd99;
        #1;
        check("bcast_unlocked_rdy", a_bus_rdy, 1);
        cyc();
        bus_vld = 1'b0;

        set_tag(3'd2);
        check("lock_tag2", a_tag_lock, 1);
        set_tag(3'd5);
        check("relock_ignored", a_tag_lock, 1);

        // Weights 1,2,3 with interleaved beats that must be dropped.
        send(1'b0, 3'd1, 16'd77);
        send(1'b0, 3'd2, 16'd1);
        send(1'b0, 3'd5, 16'd50);
        send(1'b0, 3'b111, 16'd2);
        send(1'b0, 3'd2, 16'd3);
        send(1'b1, 3'd2, 16'd1);
        send(1'b1, 3'd2, 16'd1);
        send(1'b1, 3'd2, 16'd1);
        send(1'b1, 3'd2, 16'd2);
        send(1'b1, 3'd2, 16'd0);
        send(1'b1, 3'd2, 16'hFFFF);

        start_job(4'd3, 16'd2, 1'b1);
        check("busy_after_start", a_busy, 1);
        wait_out("k3_out0", 32'd6, 16'd6, lat);
        check("k3_latency0", lat, 7);
        check("busy_mid_job", a_busy, 1);
        wait_out("k3_out1", 32'hFFFF_FFFF, 16'hFFFF, lat);
        check("k3_latency1", lat, 4);
        check("busy_done", a_busy, 0);

        // Tag clear; clear wins over a simultaneous load; then lock to tag 0.
        cfg_tag_clr = 1'b1;
        cyc();
        check("clr_unlock", a_tag_lock, 0);
        cfg_tag_vld = 1'b1; cfg_tag = 3'd0;
        cyc();
        cfg_tag_clr = 1'b0; cfg_tag_vld = 1'b0;
        check("clr_wins", a_tag_lock, 0);
        set_tag(3'd0);
        check("lock_tag0", a_tag_lock, 1);

        send(1'b1, 3'd2, 16'd9);
        send(1'b0, 3'b111, 16'd2);
        send(1'b1, 3'd0, 16'd5);

        // Chained psum with delayed upstream: 2*5 + 100.
        start_job(4'd1, 16'd1, 1'b0);
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            check("psum_rdy_held", {a_psum_in_rdy, b_psum_in_rdy}, 2'b11);
            check("psum_out_not_yet", a_psum_out_vld, 0);
            cyc();
        end
        psum_in_vld = 1'b1; psum_in = 32'd100;
        #1;
        check("psum_rdy_accept", a_psum_in_rdy, 1);
        cyc();
        psum_in_vld = 1'b0;
        check("psum_out_vld", a_psum_out_vld, 1);
        check("psum_out_a", a_psum_out, 32'd110);
        check("psum_out_b", b_psum_out, 16'd110);
        check("psum_in_rdy_drop", a_psum_in_rdy, 0);
        cyc();
        cyc();
        check("psum_out_held", {a_psum_out_vld, a_psum_out}, {1'b1, 32'd110});
        psum_out_rdy = 1'b1;
        cyc();
        psum_out_rdy = 1'b0;
        check("psum_job_done", a_busy, 0);

        // Starve LOAD_W, fill the ifmap FIFO, then check backpressure and overflow behaviour.
        start_job(4'd2, 16'd4, 1'b1);
        for (int i = 0; i < 8; i++) send(1'b1, 3'd0, 16'h7FFF);
        bus_vld = 1'b1; bus_kind = 1'b1; bus_tag = 3'd0; bus_data = 16'h1234;
        #1;
        check("x_full_rdy", {a_bus_rdy, b_bus_rdy}, 2'b00);
        cyc();
        check("x_full_rdy_hold", a_bus_rdy, 0);
        bus_kind = 1'b0; bus_data = 16'h7FFF;
        #1;
        check("w_while_x_full", {a_bus_rdy, b_bus_rdy}, 2'b11);
        cyc();
        bus_vld = 1'b0;
        send(1'b0, 3'd0, 16'h7FFF);
        for (int i = 0; i < 4; i++) begin
`ifdef GLB_PE_SAT_EN
            wait_out("ovf_out", 32'h7FFE_0002, 16'h7FFF, lat);
`else
            wait_out("ovf_out", 32'h7FFE_0002, 16'h0002, lat);
`endif
        end
        check("ovf_job_done", a_busy, 0);
`ifdef GLB_PE_SAT_EN
        check("sat_flag_a", a_sat, 0);
        check("sat_flag_b", b_sat, 1);
        start_job(4'd1, 16'd1, 1'b1);
        check("sat_flag_cleared", b_sat, 0);
`else
        start_job(4'd1, 16'd1, 1'b1);
`endif

        // Reset mid-job clears state immediately.
        check("busy_before_rst", a_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {a_busy, b_busy}, 2'b00);
        check("rst_mid_lock", {a_tag_lock, b_tag_lock}, 2'b00);
        check("rst_mid_acc", a_psum_out, 32'd0);
        @(negedge clk) rst = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
